// File: rtl/vend_pkg.sv
// Shared types for the two-channel cola vending arbiter: coin encodings,
// arbiter state encoding and the per-channel credit width.
package vend_pkg;

    localparam int CREDIT_W = 3;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_HALF = 2'b01,
        COIN_ONE  = 2'b10,
        COIN_BAD  = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DISP_A = 2'b01,
        DISP_B = 2'b10
    } state_e;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    function automatic logic [CREDIT_W-1:0] coin_value(input coin_e coin);
        case (coin)
            COIN_HALF: return CREDIT_W'(1);
            COIN_ONE:  return CREDIT_W'(2);
            default:   return CREDIT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/vend_channel.sv
// One vending channel: accumulates coin credit in half-yuan units, raises a
// service request at PRICE and refuses coins it cannot take.
module vend_channel
    import vend_pkg::*;
#(
    parameter int PRICE = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [1:0]          coin_i,
    input  logic                serving_i,
    input  logic                clear_i,
    output logic                req_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                reject_o
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    coin_e               coin;
    logic                refuse;

    assign coin  = coin_e'(coin_i);
    assign req_o = (credit_q >= PRICE_C);

    // Below PRICE the credit is at most 5, so adding a 1-yuan coin cannot overflow.
    always_comb begin
        refuse   = (coin == COIN_BAD) ||
                   ((coin != COIN_NONE) && (req_o || serving_i));
        reject_d = refuse;
        credit_d = credit_q;
        if (clear_i) begin
            credit_d = '0;
        end else if (!refuse) begin
            credit_d = credit_q + coin_value(coin);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign credit_o = credit_q;
    assign reject_o = reject_q;

endmodule

// File: rtl/vend_arbiter.sv
// Two-channel cola vending arbiter sharing one dispenser; round-robin on ties.
//   state  | meaning
//   IDLE   | dispenser off, waiting for a channel to reach PRICE
//   DISP_A | dispensing for channel A, counter running
//   DISP_B | dispensing for channel B, counter running
module vend_arbiter
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int DISP_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] pi_coin_a,
    input  logic [1:0] pi_coin_b,
    output logic       po_disp_en,
    output logic       po_cola_a,
    output logic       po_cola_b,
    output logic       po_change_a,
    output logic       po_change_b,
    output logic       po_reject_a,
    output logic       po_reject_b,
    output logic       po_busy
);

    localparam logic [7:0]          CNT_LOAD = 8'(DISP_CYC - 1);
    localparam logic [CREDIT_W-1:0] PRICE_P1 = CREDIT_W'(PRICE + 1);

    state_e     state_q, state_d;
    last_e      last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       disp_q, disp_d;
    logic       busy_q, busy_d;
    logic       cola_a_q, cola_a_d, cola_b_q, cola_b_d;
    logic       change_a_q, change_a_d, change_b_q, change_b_d;

    logic                req_a, req_b;
    logic [CREDIT_W-1:0] credit_a, credit_b;
    logic                serve_a, serve_b, clear_a, clear_b;

    assign serve_a = (state_q == DISP_A);
    assign serve_b = (state_q == DISP_B);
    assign clear_a = serve_a && (cnt_q == 8'd0);
    assign clear_b = serve_b && (cnt_q == 8'd0);

    vend_channel #(.PRICE(PRICE)) u_chan_a (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .coin_i    (pi_coin_a),
        .serving_i (serve_a),
        .clear_i   (clear_a),
        .req_o     (req_a),
        .credit_o  (credit_a),
        .reject_o  (po_reject_a)
    );

    vend_channel #(.PRICE(PRICE)) u_chan_b (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .coin_i    (pi_coin_b),
        .serving_i (serve_b),
        .clear_i   (clear_b),
        .req_o     (req_b),
        .credit_o  (credit_b),
        .reject_o  (po_reject_b)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        cola_a_d   = 1'b0;
        cola_b_d   = 1'b0;
        change_a_d = 1'b0;
        change_b_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_q == LAST_B)) begin
                    state_d = DISP_A;
                    cnt_d   = CNT_LOAD;
                end else if (req_b) begin
                    state_d = DISP_B;
                    cnt_d   = CNT_LOAD;
                end
            end
            DISP_A: begin
                if (cnt_q == 8'd0) begin
                    state_d    = IDLE;
                    last_d     = LAST_A;
                    cola_a_d   = 1'b1;
                    change_a_d = (credit_a == PRICE_P1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DISP_B: begin
                if (cnt_q == 8'd0) begin
                    state_d    = IDLE;
                    last_d     = LAST_B;
                    cola_b_d   = 1'b1;
                    change_b_d = (credit_b == PRICE_P1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered from next state so the dispenser drops on the ending edge.
        disp_d = (state_d != IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            last_q     <= LAST_B;
            cnt_q      <= 8'd0;
            disp_q     <= 1'b0;
            busy_q     <= 1'b0;
            cola_a_q   <= 1'b0;
            cola_b_q   <= 1'b0;
            change_a_q <= 1'b0;
            change_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            cola_a_q   <= cola_a_d;
            cola_b_q   <= cola_b_d;
            change_a_q <= change_a_d;
            change_b_q <= change_b_d;
        end
    end

    assign po_disp_en  = disp_q;
    assign po_busy     = busy_q;
    assign po_cola_a   = cola_a_q;
    assign po_cola_b   = cola_b_q;
    assign po_change_a = change_a_q;
    assign po_change_b = change_b_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed bench for vend_arbiter at PRICE=3, DISP_CYC=4 with hand-computed
// expectations; inputs change and outputs are sampled 1 time unit after each edge.
module tb_vend_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] pi_coin_a = 2'b00;
    logic [1:0] pi_coin_b = 2'b00;
    logic       po_disp_en, po_cola_a, po_cola_b, po_change_a, po_change_b;
    logic       po_reject_a, po_reject_b, po_busy;

    int n_chk  = 0;
    int n_pass = 0;

    vend_arbiter #(.PRICE(3), .DISP_CYC(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .pi_coin_a   (pi_coin_a),
        .pi_coin_b   (pi_coin_b),
        .po_disp_en  (po_disp_en),
        .po_cola_a   (po_cola_a),
        .po_cola_b   (po_cola_b),
        .po_change_a (po_change_a),
        .po_change_b (po_change_b),
        .po_reject_a (po_reject_a),
        .po_reject_b (po_reject_b),
        .po_busy     (po_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic coins(input logic [1:0] a, input logic [1:0] b);
        pi_coin_a = a;
        pi_coin_b = b;
        tick();
        pi_coin_a = 2'b00;
        pi_coin_b = 2'b00;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        ticks(2);
        sys_rst = 1'b0;
    endtask

    task automatic wait_cola(input bit chan_b, input string tag);
        int n = 0;
        while (!(chan_b ? po_cola_b : po_cola_a) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n >= 20), 32'd0);
    endtask

    initial begin
        // reset with coins present: no rejects, everything cleared
        pi_coin_a = 2'b11;
        pi_coin_b = 2'b01;
        ticks(3);
        chk("rst_disp", 32'(po_disp_en), 0);
        chk("rst_busy", 32'(po_busy), 0);
        chk("rst_rej_a", 32'(po_reject_a), 0);
        chk("rst_rej_b", 32'(po_reject_b), 0);
        chk("rst_cred_a", 32'(dut.credit_a), 0);
        chk("rst_cred_b", 32'(dut.credit_b), 0);
        pi_coin_a = 2'b00;
        pi_coin_b = 2'b00;
        sys_rst   = 1'b0;
        tick();

        // 0.5 + 1 yuan on A: exact price, four dispense cycles, no change
        coins(2'b01, 2'b00);
        chk("t1_cred1", 32'(dut.credit_a), 1);
        coins(2'b10, 2'b00);
        chk("t1_cred3", 32'(dut.credit_a), 3);
        chk("t1_disp_pre", 32'(po_disp_en), 0);
        tick();
        chk("t1_disp_c1", 32'(po_disp_en), 1);
        chk("t1_busy", 32'(po_busy), 1);
        ticks(3);
        chk("t1_disp_c4", 32'(po_disp_en), 1);
        chk("t1_cola_c4", 32'(po_cola_a), 0);
        tick();
        chk("t1_disp_end", 32'(po_disp_en), 0);
        chk("t1_cola", 32'(po_cola_a), 1);
        chk("t1_change", 32'(po_change_a), 0);
        chk("t1_cred0", 32'(dut.credit_a), 0);
        chk("t1_busy_end", 32'(po_busy), 0);
        tick();
        chk("t1_cola_once", 32'(po_cola_a), 0);

        // 1 + 1 yuan on A: credit 4, cola and change together
        coins(2'b10, 2'b00);
        coins(2'b10, 2'b00);
        chk("t2_cred4", 32'(dut.credit_a), 4);
        ticks(4);
        chk("t2_disp_c4", 32'(po_disp_en), 1);
        tick();
        chk("t2_cola", 32'(po_cola_a), 1);
        chk("t2_change", 32'(po_change_a), 1);
        chk("t2_cred0", 32'(dut.credit_a), 0);
        tick();
        chk("t2_change_once", 32'(po_change_a), 0);

        // tie after reset: A first, one idle cycle, then B
        do_reset();
        coins(2'b01, 2'b01);
        coins(2'b10, 2'b10);
        chk("t3_cred_a", 32'(dut.credit_a), 3);
        chk("t3_cred_b", 32'(dut.credit_b), 3);
        ticks(5);
        chk("t3_cola_a", 32'(po_cola_a), 1);
        chk("t3_cola_b_no", 32'(po_cola_b), 0);
        chk("t3_gap_disp", 32'(po_disp_en), 0);
        chk("t3_b_waiting", 32'(dut.credit_b), 3);
        tick();
        chk("t3_b_disp", 32'(po_disp_en), 1);
        ticks(4);
        chk("t3_cola_b", 32'(po_cola_b), 1);
        chk("t3_cola_a_no", 32'(po_cola_a), 0);

        // A alone, then a second tie goes to B
        coins(2'b10, 2'b00);
        coins(2'b01, 2'b00);
        wait_cola(1'b0, "t3_a_only_to");
        tick();
        coins(2'b01, 2'b01);
        coins(2'b10, 2'b10);
        wait_cola(1'b1, "t3_tie2_to");
        chk("t3_tie2_b_first", 32'(po_cola_a), 0);
        chk("t3_tie2_a_wait", 32'(dut.credit_a), 3);
        wait_cola(1'b0, "t3_tie2_a_to");

        // rejects: coin on A while A dispenses, bad coin on idle B
        do_reset();
        coins(2'b10, 2'b00);
        coins(2'b01, 2'b00);
        tick();
        chk("t4_disp", 32'(po_disp_en), 1);
        coins(2'b10, 2'b11);
        chk("t4_rej_a", 32'(po_reject_a), 1);
        chk("t4_rej_b", 32'(po_reject_b), 1);
        chk("t4_cred_a", 32'(dut.credit_a), 3);
        chk("t4_cred_b", 32'(dut.credit_b), 0);
        // half coin on B during A's dispense is accepted
        coins(2'b00, 2'b01);
        chk("t4_rej_a_once", 32'(po_reject_a), 0);
        chk("t4_rej_b_once", 32'(po_reject_b), 0);
        chk("t4_b_accept", 32'(dut.credit_b), 1);
        wait_cola(1'b0, "t4_cola_to");
        chk("t4_b_kept", 32'(dut.credit_b), 1);

        // reset in the 2nd dispense cycle forfeits the cola
        do_reset();
        coins(2'b10, 2'b00);
        coins(2'b01, 2'b00);
        tick();
        tick();
        chk("t5_disp_c2", 32'(po_disp_en), 1);
        sys_rst   = 1'b1;
        pi_coin_a = 2'b10;
        tick();
        chk("t5_disp_off", 32'(po_disp_en), 0);
        chk("t5_busy_off", 32'(po_busy), 0);
        chk("t5_no_rej", 32'(po_reject_a), 0);
        chk("t5_cred0", 32'(dut.credit_a), 0);
        sys_rst   = 1'b0;
        pi_coin_a = 2'b00;
        begin
            int n_cola = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (po_cola_a || po_change_a) n_cola++;
            end
            chk("t5_no_cola", 32'(n_cola), 0);
        end
        chk("t5_cred_after", 32'(dut.credit_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
